// File: rtl/xz_scrub_pkg.sv
// Shared types for the X/Z scrub stage: four-state word, its two-state twin,
// the buffered entry and the output buffer occupancy encoding.
package xz_scrub_pkg;

    localparam int unsigned WORD_BITS = 36;
    localparam int unsigned TRIADS    = 12;

    typedef logic [3:4][1:3][0:1][0:2] xz_word_t;
    typedef bit   [3:4][1:3][0:1][0:2] xz_clean_t;

    typedef struct packed {
        xz_clean_t         data;
        logic [TRIADS-1:0] flags;
        logic [5:0]        xz_cnt;
    } xz_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/xz_scrub_comb.sv
// Combinational scrub: replaces X/Z bits with FILL, counts them and raises
// one flag per 3-bit triad that contained any unknown bit.
module xz_scrub_comb
    import xz_scrub_pkg::*;
#(
    parameter logic FILL = 1'b0
) (
    input  xz_word_t          in_data,
    output xz_clean_t         out_data,
    output logic [TRIADS-1:0] out_flags,
    output logic [5:0]        out_xz_cnt
);

    logic [WORD_BITS-1:0] flat_in;
    logic [WORD_BITS-1:0] flat_out;
    logic                 unk;

    // Triad t occupies flat bits 35-3t down to 33-3t, which puts flag index
    // plane_idx*6 + row_idx*2 + col_idx at t.
    always_comb begin
        flat_in    = in_data;
        flat_out   = '0;
        out_flags  = '0;
        out_xz_cnt = '0;
        unk        = 1'b0;
        for (int unsigned t = 0; t < TRIADS; t++) begin
            for (int unsigned k = 0; k < 3; k++) begin
                unk = $isunknown(flat_in[WORD_BITS-1-3*t-k]);
                flat_out[WORD_BITS-1-3*t-k] = unk ? FILL : flat_in[WORD_BITS-1-3*t-k];
                out_flags[t] = out_flags[t] | unk;
                out_xz_cnt   = out_xz_cnt + {5'd0, unk};
            end
        end
    end

    assign out_data = flat_out;

endmodule

// File: rtl/xz_scrub_stage.sv
// X/Z scrub stage: scrubs each accepted word, buffers it in a 2-entry FIFO
// and keeps saturating dirty-word count plus a sticky error flag.
module xz_scrub_stage
    import xz_scrub_pkg::*;
#(
    parameter logic        FILL  = 1'b0,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  xz_word_t          in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output xz_clean_t         out_data,
    output bit [TRIADS-1:0]   out_flags,
    output logic [5:0]        out_xz_cnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  dirty_cnt,
    output logic              sticky_err,
    input  logic              clear
);

    xz_clean_t         scrub_data;
    logic [TRIADS-1:0] scrub_flags;
    logic [5:0]        scrub_xz_cnt;

    xz_scrub_comb #(.FILL(FILL)) u_comb (
        .in_data    (in_data),
        .out_data   (scrub_data),
        .out_flags  (scrub_flags),
        .out_xz_cnt (scrub_xz_cnt)
    );

    occ_e             occ_q, occ_d;
    xz_entry_t        mem_q [2];
    xz_entry_t        mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] dirty_q, dirty_d;
    logic             sticky_q, sticky_d;

    logic in_valid_s, out_ready_s, acc, pop;

    // Handshake inputs that are X or Z count as deasserted.
    assign in_valid_s  = (in_valid === 1'b1);
    assign out_ready_s = (out_ready === 1'b1);
    assign acc         = in_valid_s && in_ready_q;
    assign pop         = out_valid_q && out_ready_s;

    always_comb begin
        occ_d    = occ_q;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        dirty_d  = dirty_q;
        sticky_d = sticky_q;

        if (acc) begin
            mem_d[wr_ptr_q] = '{data: scrub_data, flags: scrub_flags, xz_cnt: scrub_xz_cnt};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case (occ_q)
            OCC_EMPTY: if (acc) occ_d = OCC_ONE;
            OCC_ONE: begin
                if (acc && !pop)      occ_d = OCC_FULL;
                else if (!acc && pop) occ_d = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) occ_d = OCC_ONE;
            default:   occ_d = OCC_EMPTY;
        endcase

        in_ready_d  = (occ_d != OCC_FULL);
        out_valid_d = (occ_d != OCC_EMPTY);

        // Clear first so a coincident dirty accept still counts once.
        if (clear) begin
            dirty_d  = '0;
            sticky_d = 1'b0;
        end
        if (acc && (scrub_xz_cnt != 6'd0)) begin
            sticky_d = 1'b1;
            if (dirty_d != {CNT_W{1'b1}}) dirty_d = dirty_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q       <= OCC_EMPTY;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dirty_q     <= '0;
            sticky_q    <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            dirty_q     <= dirty_d;
            sticky_q    <= sticky_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = mem_q[rd_ptr_q].data;
    assign out_flags  = mem_q[rd_ptr_q].flags;
    assign out_xz_cnt = mem_q[rd_ptr_q].xz_cnt;
    assign dirty_cnt  = dirty_q;
    assign sticky_err = sticky_q;

endmodule

// File: tb/tb_xz_scrub_stage.sv
// Directed bench for xz_scrub_stage: instance a uses FILL=0/CNT_W=16,
// instance b uses FILL=1/CNT_W=2; both see the same stimulus.
module tb_xz_scrub_stage;
    import xz_scrub_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic     rst, in_valid, out_ready, clear;
    xz_word_t in_data;

    logic              a_in_ready, a_out_valid, a_sticky;
    xz_clean_t         a_out_data;
    bit [TRIADS-1:0]   a_out_flags;
    logic [5:0]        a_out_xz_cnt;
    logic [15:0]       a_dirty;

    logic              b_in_ready, b_out_valid, b_sticky;
    xz_clean_t         b_out_data;
    bit [TRIADS-1:0]   b_out_flags;
    logic [5:0]        b_out_xz_cnt;
    logic [1:0]        b_dirty;

    xz_scrub_stage #(.FILL(1'b0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_flags(a_out_flags),
        .out_xz_cnt(a_out_xz_cnt), .out_valid(a_out_valid), .out_ready(out_ready),
        .dirty_cnt(a_dirty), .sticky_err(a_sticky), .clear(clear)
    );

    xz_scrub_stage #(.FILL(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_flags(b_out_flags),
        .out_xz_cnt(b_out_xz_cnt), .out_valid(b_out_valid), .out_ready(out_ready),
        .dirty_cnt(b_dirty), .sticky_err(b_sticky), .clear(clear)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic     probe;
    bit       four_state;
    xz_word_t w_clean, w_dirty, w_allz, w_a, w_b, w_c, w_d, w_e;

    initial begin
        probe      = 1'bx;
        four_state = $isunknown(probe);
        w_clean = 36'h0_F0F0_A5A5;
        w_a     = 36'hA_1111_1111;
        w_b     = 36'hB_2222_2222;
        w_c     = 36'hC_3333_3333;
        w_d     = 36'h1_2345_6789;
        w_e     = 36'h9_8765_4321;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0; in_data = '0;
        tick();
        tick();
        check_eq("rst_out_valid", a_out_valid, 0);
        check_eq("rst_in_ready", a_in_ready, 1);
        check_eq("rst_out_data", a_out_data, 0);
        check_eq("rst_out_flags", a_out_flags, 0);
        check_eq("rst_xz_cnt", a_out_xz_cnt, 0);
        check_eq("rst_dirty", a_dirty, 0);
        check_eq("rst_sticky", b_sticky, 0);
        rst = 1'b0;
        tick();

        // Clean word passes through unchanged with one cycle latency.
        in_data = w_clean; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check_eq("clean_valid", a_out_valid, 1);
        check_eq("clean_data_a", a_out_data, 36'h0_F0F0_A5A5);
        check_eq("clean_data_b", b_out_data, 36'h0_F0F0_A5A5);
        check_eq("clean_xz", a_out_xz_cnt, 0);
        check_eq("clean_flags", a_out_flags, 0);
        check_eq("clean_dirty", a_dirty, 0);
        in_valid = 1'b0;
        tick();
        check_eq("clean_drained", a_out_valid, 0);

        if (four_state) begin
            w_dirty = w_clean;
            w_dirty[3][1][0][0] = 1'bx;
            w_dirty[4][3][1][2] = 1'bz;
            w_allz = 'z;
            in_data = w_dirty; in_valid = 1'b1;
            tick();
            check_eq("xz2_data_a", a_out_data, 36'h0_F0F0_A5A4);
            check_eq("xz2_data_b", b_out_data, 36'h8_F0F0_A5A5);
            check_eq("xz2_cnt", b_out_xz_cnt, 2);
            check_eq("xz2_flags", b_out_flags, 12'h801);
            check_eq("xz2_sticky", b_sticky, 1);
            check_eq("xz2_dirty", b_dirty, 1);
            in_data = w_allz;
            tick();
            check_eq("allz_data_a", a_out_data, 0);
            check_eq("allz_data_b", b_out_data, 36'hF_FFFF_FFFF);
            check_eq("allz_cnt", a_out_xz_cnt, 36);
            check_eq("allz_flags", a_out_flags, 12'hFFF);
            check_eq("allz_dirty_b", b_dirty, 2);
            tick();
            tick();
            tick();
            check_eq("sat_dirty_b", b_dirty, 3);
            check_eq("nosat_dirty_a", a_dirty, 5);
            clear = 1'b1;
            tick();
            check_eq("clracc_dirty_a", a_dirty, 1);
            check_eq("clracc_dirty_b", b_dirty, 1);
            check_eq("clracc_sticky", a_sticky, 1);
            clear = 1'b0; in_valid = 1'b0;
            tick();
        end

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_dirty", a_dirty, 0);
        check_eq("clr_sticky", a_sticky, 0);
        tick();

        // Backpressure: two accepts fill the buffer, the third waits for a pop.
        out_ready = 1'b0; in_valid = 1'b1; in_data = w_a;
        tick();
        check_eq("bp1_in_ready", a_in_ready, 1);
        check_eq("bp1_data", a_out_data, 36'hA_1111_1111);
        in_data = w_b;
        tick();
        check_eq("bp2_in_ready", a_in_ready, 0);
        check_eq("bp2_data", a_out_data, 36'hA_1111_1111);
        in_data = w_c;
        tick();
        check_eq("bp3_in_ready", a_in_ready, 0);
        check_eq("bp3_hold", a_out_data, 36'hA_1111_1111);
        check_eq("bp3_valid", a_out_valid, 1);
        out_ready = 1'b1;
        tick();
        check_eq("pop1_data", a_out_data, 36'hB_2222_2222);
        check_eq("pop1_in_ready", a_in_ready, 1);
        tick();
        check_eq("pop2_data", a_out_data, 36'hC_3333_3333);
        check_eq("pop2_valid", a_out_valid, 1);
        in_valid = 1'b0;
        tick();
        check_eq("pop3_empty", a_out_valid, 0);

        // Reset while full discards buffered words and statistics.
        w_d[3][1][0][0] = four_state ? 1'bx : 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = w_d;
        tick();
        in_data = w_e;
        tick();
        check_eq("full_in_ready", a_in_ready, 0);
        rst = 1'b1; out_ready = 1'b1;
        tick();
        check_eq("rstf_valid", a_out_valid, 0);
        check_eq("rstf_in_ready", a_in_ready, 1);
        check_eq("rstf_dirty", a_dirty, 0);
        check_eq("rstf_sticky", a_sticky, 0);
        check_eq("rstf_data", a_out_data, 0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check_eq("rstf_no_stale1", a_out_valid, 0);
        tick();
        check_eq("rstf_no_stale2", b_out_valid, 0);
        check_eq("rstf_xz", a_out_xz_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xz_scrub_stage.md
# xz_scrub_stage

Downstream consumer for the 36-bit four-state bus organised as [3:4][1:3][0:1][0:2] (two planes × three rows × two columns × three bits). It accepts one four-state word per valid/ready handshake, replaces every X/Z bit with a parameterised fill value, and counts the unknown bits. It forwards a clean two-state word with per-triad unknown flags through a 2-entry output buffer, and keeps sticky and saturating statistics for the bench. The block is simulation-targeted: X/Z detection uses four-state comparison and is not synthesisable as hardware detection.

## Interface
- FILL, default 1'b0: value substituted for every X or Z input bit.
- CNT_W, default 16: width of the dirty-word statistics counter.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  logic [3:4][1:3][0:1][0:2]  four-state input word.
- in_valid  in  1  input word present.
- in_ready  out  1  stage can accept a word this cycle.
- out_data  out  bit [3:4][1:3][0:1][0:2]  scrubbed two-state word.
- out_flags  out  bit [11:0]  one bit per triad, set if any of its 3 bits was X/Z. Index = plane_idx*6 + row_idx*2 + col_idx, where plane_idx = plane−3, row_idx = row−1, col_idx = col.
- out_xz_cnt  out  6  number of X/Z bits in the word, 0..36.
- out_valid  out  1  buffered word present.
- out_ready  in  1  consumer accepts the word.
- dirty_cnt  out  CNT_W  saturating count of accepted words with out_xz_cnt ≠ 0.
- sticky_err  out  1  set on the first dirty accepted word; held until clear.
- clear  in  1  synchronous clear of dirty_cnt and sticky_err.

## Operation
- Scrub is combinational on in_data.
  - Each bit b maps to FILL if b is X or Z, otherwise to b.
  - xz_cnt is the population count of unknown bits.
  - The triad flag is the OR of the unknown indications for its 3 bits.
- Accept happens when in_valid && in_ready. The scrubbed tuple {data, flags, xz_cnt} is written into the buffer.
- A known X or Z on in_valid or out_ready is treated as 0.
- Buffer: 2-entry FIFO; state is the occupancy EMPTY(0), ONE(1), FULL(2).
  - EMPTY: accept → ONE.
  - ONE: accept and pop → ONE. Accept only → FULL. Pop only → EMPTY.
  - FULL: pop only → ONE. No accept is possible.
  - in_ready = (occupancy ≠ FULL). It is a registered decode and does not depend combinationally on out_ready.
  - Pop happens when out_valid && out_ready. out_valid = (occupancy ≠ EMPTY).
  - out_* always shows the head entry.
- Statistics:
  - dirty_cnt increments on each dirty accept and saturates at 2^CNT_W−1.
  - sticky_err sets on a dirty accept.
  - If clear is high in the same cycle as a dirty accept, the result is dirty_cnt = 1 and sticky_err = 1: the accept wins after the clear.
- Reset values:
  - occupancy EMPTY, out_valid 0, in_ready 1.
  - out_data 0, out_flags 0, out_xz_cnt 0.
  - dirty_cnt 0, sticky_err 0.
- Reset has priority over accept, pop and clear. Buffered words are discarded on reset, including in the middle of a transfer.

## Timing
- Latency is 1 cycle: a word accepted at edge N is visible on out_* after edge N with out_valid = 1.
- Throughput is 1 word/cycle while out_ready is held high.
- With out_ready low, two words are accepted and in_ready drops the cycle after the second accept.
- From FULL, simultaneous accept and pop cannot occur because in_ready is 0. in_ready returns 1 the cycle after a pop.
- Statistics update on the same edge as the accept.
- out_data and out_flags are stable while out_valid && !out_ready. Order is strict FIFO.

## Structure
- Package xz_scrub_pkg holds:
  - the typedef for the word, logic [3:4][1:3][0:1][0:2];
  - its two-state twin, bit [3:4][1:3][0:1][0:2];
  - WORD_BITS = 36, TRIADS = 12;
  - the entry struct {data, flags, xz_cnt}.
- Sub-module xz_scrub_comb: purely combinational scrub, popcount and flag generation, kept separate for unit checks. The top level holds the FIFO, occupancy and statistics.

## Test plan
- Reset then clean word 36'h0_F0F0_A5A5, FILL = 0, out_ready = 1 → next cycle out_data = same value, out_xz_cnt = 0, out_flags = 0, dirty_cnt = 0.
- Word with bit [3][1][0][0] = X and bit [4][3][1][2] = Z, FILL = 1 → those bits read 1, out_xz_cnt = 2, out_flags = 12'h801, sticky_err = 1, dirty_cnt = 1.
- All-Z word → out_xz_cnt = 36, out_flags = 12'hFFF, out_data = all FILL.
- out_ready = 0 with 3 back-to-back valids:
  - two words are accepted, in_ready = 0 after the second, and the third is held;
  - raising out_ready drains the words in order, and the third is accepted the cycle after the first pop.
- CNT_W = 2 with 5 dirty accepts → dirty_cnt saturates at 3. clear coinciding with a dirty accept → dirty_cnt = 1, sticky_err = 1.
- rst asserted with FULL buffer → next cycle out_valid = 0, in_ready = 1, statistics = 0, and no stale word emerges afterwards.
